writeback_arbiter: RTL and testbench

//  Writeback stage directly upstream of regfile: merges ALU results and load

---
 rtl/writeback_arbiter.sv | 141 ++++++++++++++
 tb/tb_writeback_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges load responses (priority) and FIFO-buffered ALU
// results onto the single regfile write port, with a pending-write lookup for decode.
module writeback_arbiter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid_i,
  output logic            alu_ready_o,
  input  logic [4:0]      alu_rd_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic            ld_valid_i,
  input  logic [4:0]      ld_rd_i,
  input  logic [31:0]     ld_data_i,
  input  logic [2:0]      ld_funct3_i,
  input  logic [1:0]      ld_offset_i,
  input  logic [4:0]      lookup_rd_pi,
  output logic            pending_o,
  output logic [4:0]      destReg_po,
  output logic [XLEN-1:0] writeData_po,
  output logic            we_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;

  logic full, empty, push, pop;

  assign full        = (count == (PTR_W+1)'(DEPTH));
  assign empty       = (count == '0);
  assign alu_ready_o = !full;
  assign push        = alu_valid_i && !full;
  assign pop         = !ld_valid_i && !empty;

  // Load data extraction and extension
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_result;

  always_comb begin
    ld_byte = ld_data_i[7:0];
    case (ld_offset_i)
      2'd0: ld_byte = ld_data_i[7:0];
      2'd1: ld_byte = ld_data_i[15:8];
      2'd2: ld_byte = ld_data_i[23:16];
      2'd3: ld_byte = ld_data_i[31:24];
      default: ld_byte = ld_data_i[7:0];
    endcase
    ld_half = ld_offset_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];
  end

  always_comb begin
    ld_result = XLEN'(ld_data_i);
    case (ld_funct3_i)
      3'b000:  ld_result = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_result = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_result = XLEN'(ld_byte);
      3'b101:  ld_result = XLEN'(ld_half);
      default: ld_result = XLEN'(ld_data_i);
    endcase
  end

  // Source select: loads always win, FIFO head only when no load
  logic            sel_valid;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;

  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (ld_valid_i) begin
      sel_valid = 1'b1;
      sel_rd    = ld_rd_i;
      sel_data  = ld_result;
    end else if (!empty) begin
      sel_valid = 1'b1;
      sel_rd    = fifo_rd[rd_ptr];
      sel_data  = fifo_data[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= alu_rd_i;
      fifo_data[wr_ptr] <= alu_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_o         <= 1'b0;
      destReg_po   <= '0;
      writeData_po <= '0;
    end else if (sel_valid) begin
      we_o         <= (sel_rd != '0);
      destReg_po   <= sel_rd;
      writeData_po <= sel_data;
    end else begin
      we_o <= 1'b0;
    end
  end

  // An entry is live when its distance from the head is below the occupancy
  logic             fifo_hit;
  logic [PTR_W-1:0] rel;

  always_comb begin
    fifo_hit = 1'b0;
    rel      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rel = PTR_W'(i) - rd_ptr;
      if (((PTR_W+1)'(rel) < count) && (fifo_rd[i] == lookup_rd_pi))
        fifo_hit = 1'b1;
    end
    pending_o = (lookup_rd_pi != '0) &&
                (fifo_hit || (we_o && (destReg_po == lookup_rd_pi)));
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: load-extract vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_writeback_arbiter;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        ld_valid_i;
  logic [4:0]  ld_rd_i;
  logic [31:0] ld_data_i;
  logic [2:0]  ld_funct3_i;
  logic [1:0]  ld_offset_i;
  logic [4:0]  lookup_rd_pi;
  logic        pending_o;
  logic [4:0]  destReg_po;
  logic [31:0] writeData_po;
  logic        we_o;

  writeback_arbiter #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .ld_valid_i(ld_valid_i), .ld_rd_i(ld_rd_i), .ld_data_i(ld_data_i),
    .ld_funct3_i(ld_funct3_i), .ld_offset_i(ld_offset_i),
    .lookup_rd_pi(lookup_rd_pi), .pending_o(pending_o),
    .destReg_po(destReg_po), .writeData_po(writeData_po), .we_o(we_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] word;
    logic [4:0]  rd;
    logic        exp_we;
    logic [31:0] exp_data;
  } ld_vec_t;

  ld_vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld_ref(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) % 32'd256;
    h = (w >> ((off >= 2'd2) ? 16 : 0)) % 32'd65536;
    case (f3)
      3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_we = 1'b0;
    m_rd = '0;
    m_data = '0;
  endtask

  task automatic idle_inputs();
    alu_valid_i = 1'b0; alu_rd_i = '0; alu_data_i = '0;
    ld_valid_i = 1'b0; ld_rd_i = '0; ld_data_i = '0;
    ld_funct3_i = 3'b010; ld_offset_i = '0;
  endtask

  // One clock: check combinational outputs mid-cycle, advance model at the edge,
  // then check registered outputs just after the edge.
  task automatic tick(output logic rdy_s, output logic pend_s);
    ent_t        e;
    logic        sel;
    logic [4:0]  srd;
    logic [31:0] sdata;
    logic        exp_rdy, exp_pend;
    #1;
    exp_rdy  = (mq.size() < DEPTH);
    exp_pend = 1'b0;
    if (lookup_rd_pi != 5'd0) begin
      foreach (mq[i]) if (mq[i].rd == lookup_rd_pi) exp_pend = 1'b1;
      if (m_we && m_rd == lookup_rd_pi) exp_pend = 1'b1;
    end
    check("alu_ready", alu_ready_o, exp_rdy);
    check("pending", pending_o, exp_pend);
    rdy_s  = alu_ready_o;
    pend_s = pending_o;
    @(posedge clk);
    sel = 1'b0; srd = '0; sdata = '0;
    if (ld_valid_i) begin
      sel = 1'b1; srd = ld_rd_i; sdata = ld_ref(ld_funct3_i, ld_offset_i, ld_data_i);
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      sel = 1'b1; srd = e.rd; sdata = e.data;
    end
    if (alu_valid_i && exp_rdy) mq.push_back('{alu_rd_i, alu_data_i});
    if (sel) begin
      m_we = (srd != 5'd0); m_rd = srd; m_data = sdata;
    end else begin
      m_we = 1'b0;
    end
    #1;
    check("we", we_o, m_we);
    check("destReg", destReg_po, m_rd);
    check("writeData", writeData_po, m_data);
  endtask

  initial begin
    logic r, p;
    int acc, nw;
    logic pseq[4];

    vecs[0] = '{3'b101, 2'd2, 32'h8001_0000, 5'd3, 1'b1, 32'h0000_8001};
    vecs[1] = '{3'b001, 2'd2, 32'h8001_0000, 5'd4, 1'b1, 32'hFFFF_8001};
    vecs[2] = '{3'b100, 2'd1, 32'h0000_F000, 5'd5, 1'b1, 32'h0000_00F0};
    vecs[3] = '{3'b010, 2'd0, 32'h1234_5678, 5'd0, 1'b0, 32'h1234_5678};
    vecs[4] = '{3'b000, 2'd0, 32'hAA55_667F, 5'd8, 1'b1, 32'h0000_007F};
    vecs[5] = '{3'b001, 2'd1, 32'h1234_7FFE, 5'd9, 1'b1, 32'h0000_7FFE};
    vecs[6] = '{3'b011, 2'd3, 32'hCAFE_BABE, 5'd10, 1'b1, 32'hCAFE_BABE};
    vecs[7] = '{3'b101, 2'd3, 32'hABCD_0000, 5'd11, 1'b1, 32'h0000_ABCD};

    reset = 1'b0;
    lookup_rd_pi = '0;
    idle_inputs();
    model_reset();
    #2;
    check("rst_ready", alu_ready_o, 1'b1);
    check("rst_we", we_o, 1'b0);
    check("rst_destReg", destReg_po, 5'd0);
    check("rst_writeData", writeData_po, 32'd0);
    #10 reset = 1'b1;
    @(posedge clk); #1;

    // Reset mid-operation: loads hold off the FIFO while 3 ALU entries queue
    for (int i = 0; i < 3; i++) begin
      ld_valid_i = 1'b1; ld_rd_i = 5'd10; ld_data_i = 32'h0BAD_F00D; ld_funct3_i = 3'b010;
      alu_valid_i = 1'b1; alu_rd_i = 5'(i + 1); alu_data_i = 32'(i + 100);
      tick(r, p);
    end
    check("pre_rst_we", we_o, 1'b1);
    reset = 1'b0;
    #1;
    check("async_rst_we", we_o, 1'b0);
    check("async_rst_ready", alu_ready_o, 1'b1);
    model_reset();
    idle_inputs();
    #2 reset = 1'b1;
    for (int i = 1; i < 32; i++) begin
      lookup_rd_pi = 5'(i);
      #1 check("post_rst_pending", pending_o, 1'b0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      lookup_rd_pi = 5'(i + 1);
      tick(r, p);
      check("post_rst_nowrite", we_o, 1'b0);
    end

    // Load extraction table
    foreach (vecs[i]) begin
      idle_inputs();
      ld_valid_i = 1'b1; ld_funct3_i = vecs[i].f3; ld_offset_i = vecs[i].off;
      ld_data_i = vecs[i].word; ld_rd_i = vecs[i].rd;
      tick(r, p);
      check("vec_we", we_o, vecs[i].exp_we);
      if (vecs[i].exp_we) check("vec_data", writeData_po, vecs[i].exp_data);
    end

    // ALU latency: accepted in N, written in N+2 only
    idle_inputs();
    repeat (2) tick(r, p);
    alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hDEAD_BEEF;
    tick(r, p);
    check("alu_n1_we", we_o, 1'b0);
    idle_inputs();
    tick(r, p);
    check("alu_n2_we", we_o, 1'b1);
    check("alu_n2_rd", destReg_po, 5'd5);
    check("alu_n2_data", writeData_po, 32'hDEAD_BEEF);
    tick(r, p);
    check("alu_n3_we", we_o, 1'b0);

    // Collision: load first, ALU the cycle after
    ld_valid_i = 1'b1; ld_rd_i = 5'd6; ld_funct3_i = 3'b000; ld_offset_i = 2'd3;
    ld_data_i = 32'h8012_3456;
    alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_data_i = 32'h11;
    tick(r, p);
    check("col_ld_rd", destReg_po, 5'd6);
    check("col_ld_data", writeData_po, 32'hFFFF_FF80);
    idle_inputs();
    tick(r, p);
    check("col_alu_we", we_o, 1'b1);
    check("col_alu_rd", destReg_po, 5'd7);
    check("col_alu_data", writeData_po, 32'h11);

    // Full: loads stream for 8 cycles while ALU rd 1..5 is offered
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      ld_valid_i = 1'b1; ld_rd_i = 5'(20 + c); ld_funct3_i = 3'b010;
      ld_offset_i = '0; ld_data_i = $urandom;
      alu_valid_i = (acc < 5); alu_rd_i = 5'(acc + 1); alu_data_i = 32'(acc + 1) * 32'h100;
      tick(r, p);
      if (alu_valid_i && r) acc++;
    end
    check("full_accepts", 32'(acc), 32'd4);
    check("full_ready_low", alu_ready_o, 1'b0);
    ld_valid_i = 1'b0;
    nw = 0;
    for (int c = 0; c < 12; c++) begin
      alu_valid_i = (acc < 5); alu_rd_i = 5'(acc + 1); alu_data_i = 32'(acc + 1) * 32'h100;
      tick(r, p);
      if (alu_valid_i && r) acc++;
      if (we_o && nw < 4) begin
        check("full_order", destReg_po, 5'(nw + 1));
        nw++;
      end
    end
    check("full_writes", 32'(nw), 32'd4);

    // Pending lifetime of a queued write, and lookup 0
    idle_inputs();
    lookup_rd_pi = 5'd9;
    alu_valid_i = 1'b1; alu_rd_i = 5'd9; alu_data_i = 32'h99;
    tick(r, pseq[0]);
    idle_inputs();
    for (int i = 1; i < 4; i++) tick(r, pseq[i]);
    check("pend_n0", pseq[0], 1'b0);
    check("pend_queued", pseq[1], 1'b1);
    check("pend_writing", pseq[2], 1'b1);
    check("pend_after", pseq[3], 1'b0);
    lookup_rd_pi = 5'd0;
    alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'h5;
    tick(r, p);
    idle_inputs();
    tick(r, p);
    check("pend_rd0", p, 1'b0);
    tick(r, p);
    check("alu_rd0_we", we_o, 1'b0);

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      ld_valid_i   = ($urandom_range(0, 99) < 30);
      ld_rd_i      = 5'($urandom_range(0, 7));
      ld_data_i    = $urandom;
      ld_funct3_i  = 3'($urandom);
      ld_offset_i  = 2'($urandom);
      alu_valid_i  = ($urandom_range(0, 99) < 70);
      alu_rd_i     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      alu_data_i   = $urandom;
      lookup_rd_pi = 5'($urandom_range(0, 7));
      tick(r, p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
